// File: rtl/qspi_pkg.sv
// Shared types and default sizing for the QSPI cache line-refill engine.
// The FSM state type is exported so the top can publish it on a debug port.
package qspi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_TIMEOUT    = 255;
  localparam int DEF_ADDR_W     = 24;

endpackage

// File: rtl/qspi_line_fill_wdog.sv
// Per-word watchdog: loadable up-counter that saturates at TIMEOUT and
// flags expiry while the count equals TIMEOUT.
module fill_wdog
  import qspi_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          enable,
  output logic          expired
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_q;

  // Priority: clear, then load, then count; counting stops at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (enable && (count_q != LIMIT)) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/qspi_line_fill.sv
// Cache line-refill engine: fetches a line one QSPI word at a time, critical
// word first, with an early critical-word bypass and a per-word watchdog.
module qspi_line_fill
  import qspi_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic [ADDR_W-1:0]        qspi_addr,
  output logic                     qspi_read_en,
  input  logic                     qspi_rready,
  input  logic [31:0]              qspi_dout,
  input  logic                     qspi_dval,
  output logic                     crit_valid,
  output logic [31:0]              crit_data,
  output logic                     fill_valid,
  input  logic                     fill_ready,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic [32*LINE_WORDS-1:0] fill_data,
  output logic                     fill_err,
  output fill_state_t              dbg_state
);

  localparam int W  = $clog2(LINE_WORDS);
  localparam int TW = ADDR_W - W - 2;
  localparam int CW = $clog2(TIMEOUT + 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and once raised it holds with
  // stable payload until the transfer. qspi_read_en is the valid side of the
  // read launch and fires only in a cycle where qspi_rready is high.

  fill_state_t   state_q, state_d;
  logic [TW-1:0] tag_q;
  logic [W-1:0]  start_q;
  logic [W-1:0]  k_q;
  logic [W-1:0]  idx;
  logic [W-1:0]  next_idx;
  logic [ADDR_W-1:0] qspi_addr_q;
  logic [31:0]   line_q [LINE_WORDS];
  logic          crit_valid_q;
  logic [31:0]   crit_data_q;
  logic          err_q;

  logic accept;
  logic launch;
  logic take;
  logic timeout;
  logic wd_expired;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr[1:0];

  // Word k of the fill lands at (start + k) mod LINE_WORDS via W-bit wrap.
  assign idx      = start_q + k_q;
  assign next_idx = idx + W'(1);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    launch  = 1'b0;
    take    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (qspi_rready) begin
          launch  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A data beat arriving on the expiry cycle still counts.
        if (qspi_dval) begin
          take    = 1'b1;
          state_d = (k_q == '1) ? DONE : ISSUE;
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (fill_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q        <= '0;
      start_q      <= '0;
      k_q          <= '0;
      qspi_addr_q  <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      crit_valid_q <= 1'b0;
      if (accept) begin
        tag_q       <= req_addr[ADDR_W-1:W+2];
        start_q     <= req_addr[W+1:2];
        k_q         <= '0;
        err_q       <= 1'b0;
        qspi_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
      end
      if (take) begin
        line_q[idx] <= qspi_dout;
        if (k_q == '0) begin
          crit_valid_q <= 1'b1;
          crit_data_q  <= qspi_dout;
        end
        if (k_q != '1) begin
          k_q         <= k_q + W'(1);
          qspi_addr_q <= {tag_q, next_idx, 2'b00};
        end
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // The launch cycle counts as the first waiting cycle, so WAIT lasts at most
  // TIMEOUT cycles before the line is closed with an error.
  fill_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_q == IDLE),
    .load     (launch),
    .load_val (CW'(1)),
    .enable   (state_q == WAIT),
    .expired  (wd_expired)
  );

  assign req_ready    = (state_q == IDLE);
  assign qspi_read_en = launch;
  assign qspi_addr    = qspi_addr_q;
  assign crit_valid   = crit_valid_q;
  assign crit_data    = crit_data_q;
  assign fill_valid   = (state_q == DONE);
  assign fill_addr    = {tag_q, {(W + 2){1'b0}}};
  assign fill_err     = err_q;
  assign dbg_state    = state_q;

  for (genvar i = 0; i < LINE_WORDS; i++) begin : g_pack
    assign fill_data[32*i +: 32] = line_q[i];
  end

  a_launch_needs_ready: assert property (
    @(posedge clk) disable iff (!rst_n) qspi_read_en |-> qspi_rready);

  a_fill_held: assert property (
    @(posedge clk) disable iff (!rst_n)
    (fill_valid && !fill_ready) |=> (fill_valid && $stable(fill_data) && $stable(fill_err)));

endmodule

// File: tb/tb_qspi_line_fill.sv
// Randomized scoreboard bench for qspi_line_fill: a flash-memory reference
// model predicts address order, critical word and final line per request.
module tb_qspi_line_fill;
  import qspi_pkg::*;

  localparam int LW = 4;
  localparam int TO = 20;
  localparam int AW = 24;
  localparam int LB = LW * 4;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     req_addr;
  logic [AW-1:0]     qspi_addr;
  logic              qspi_read_en;
  logic              qspi_rready;
  logic [31:0]       qspi_dout;
  logic              qspi_dval;
  logic              crit_valid;
  logic [31:0]       crit_data;
  logic              fill_valid;
  logic              fill_ready;
  logic [AW-1:0]     fill_addr;
  logic [32*LW-1:0]  fill_data;
  logic              fill_err;
  fill_state_t       dbg_state;

  qspi_line_fill #(
    .LINE_WORDS (LW),
    .TIMEOUT    (TO),
    .ADDR_W     (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .qspi_addr    (qspi_addr),
    .qspi_read_en (qspi_read_en),
    .qspi_rready  (qspi_rready),
    .qspi_dout    (qspi_dout),
    .qspi_dval    (qspi_dval),
    .crit_valid   (crit_valid),
    .crit_data    (crit_data),
    .fill_valid   (fill_valid),
    .fill_ready   (fill_ready),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data),
    .fill_err     (fill_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [AW-1:0]    addr_q[$];
  logic [31:0]      crit_q[$];
  logic [AW-1:0]    faddr_q[$];
  logic [32*LW-1:0] fdata_q[$];
  logic             ferr_q[$];

  logic [31:0] mem [int unsigned];
  logic [31:0] line_m [LW];

  // stimulus knobs (written only by the main driver)
  bit            drop_en   = 1'b0;
  logic [AW-1:0] drop_addr = '0;
  int            fixed_lat = -1;
  bit            stray_en  = 1'b0;
  int            rr_mode   = 0;
  int            fr_mode   = 0;
  int            drop_cyc  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [31:0] rd_mem(input logic [AW-1:0] a);
    int unsigned key;
    key = a;
    if (mem.exists(key)) return mem[key];
    return 32'hDEAD_BEEF;
  endfunction

  // Reference model: flash is a word map; the line buffer persists between
  // fills, so a timed-out word keeps whatever the previous line left there.
  task automatic expect_fill(input logic [AW-1:0] a);
    int unsigned ai, base, start, idx, wa;
    bit err;
    logic [32*LW-1:0] line;
    ai    = a;
    base  = (ai / LB) * LB;
    start = (ai % LB) / 4;
    err   = 1'b0;
    for (int k = 0; k < LW; k++) begin
      idx = (start + k) % LW;
      wa  = base + 4 * idx;
      addr_q.push_back(AW'(wa));
      if (!mem.exists(wa)) mem[wa] = $urandom;
      if (drop_en && (AW'(wa) == drop_addr)) begin
        err = 1'b1;
        break;
      end
      line_m[idx] = mem[wa];
      if (k == 0) crit_q.push_back(mem[wa]);
    end
    for (int i = 0; i < LW; i++) line[32*i +: 32] = line_m[i];
    faddr_q.push_back(AW'(base));
    fdata_q.push_back(line);
    ferr_q.push_back(err);
  endtask

  // ---------------- QSPI responder ----------------
  initial begin
    bit            pend;
    bit            in_drop;
    int            cnt;
    logic [AW-1:0] pa;
    pend = 1'b0;
    in_drop = 1'b0;
    cnt = 0;
    pa = '0;
    qspi_dval = 1'b0;
    qspi_dout = '0;
    forever begin
      @(negedge clk);
      if (rst_n && qspi_read_en) begin
        if (drop_en && (qspi_addr == drop_addr)) begin
          drop_cyc = cyc;
          in_drop  = 1'b1;
          pend     = 1'b0;
        end else begin
          in_drop = 1'b0;
          pend    = 1'b1;
          pa      = qspi_addr;
          if (fixed_lat >= 0) cnt = fixed_lat;
          else cnt = ($urandom_range(0, 9) == 0) ? 19 : $urandom_range(0, 6);
        end
      end
      @(posedge clk);
      #1;
      qspi_dval = 1'b0;
      qspi_dout = $urandom;
      if (!rst_n) begin
        pend    = 1'b0;
        in_drop = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          qspi_dval = 1'b1;
          qspi_dout = rd_mem(pa);
          pend      = 1'b0;
        end else begin
          cnt--;
        end
      end else if (stray_en && !in_drop && ($urandom_range(0, 2) == 0)) begin
        qspi_dval = 1'b1;
      end
    end
  end

  // ---------------- ready drivers ----------------
  initial begin
    qspi_rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       qspi_rready = 1'b1;
        1:       qspi_rready = ($urandom_range(0, 2) != 0);
        default: qspi_rready = 1'b0;
      endcase
    end
  end

  initial begin
    fill_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (fr_mode)
        0:       fill_ready = 1'b1;
        1:       fill_ready = ($urandom_range(0, 1) != 0);
        default: fill_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (qspi_read_en) begin
        check("read_en_with_rready", qspi_rready, 1'b1);
        if (addr_q.size() == 0) note_fail("qspi_read_unexpected");
        else check("qspi_addr", qspi_addr, addr_q.pop_front());
      end
      if (crit_valid) begin
        if (crit_q.size() == 0) note_fail("crit_unexpected");
        else check("crit_data", crit_data, crit_q.pop_front());
      end
      if (fill_valid) begin
        check("req_ready_in_done", req_ready, 1'b0);
        if (fdata_q.size() == 0) begin
          note_fail("fill_unexpected");
        end else begin
          check("fill_addr", fill_addr, faddr_q[0]);
          check("fill_data", fill_data, fdata_q[0]);
          check("fill_err", fill_err, ferr_q[0]);
          if (fill_ready) begin
            void'(faddr_q.pop_front());
            void'(fdata_q.pop_front());
            void'(ferr_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [AW-1:0] a);
    int n;
    n = 0;
    expect_fill(a);
    @(negedge clk);
    req_addr  = a;
    req_valid = 1'b1;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) note_fail("req_accept_timeout");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((fdata_q.size() != 0 || addr_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) note_fail("idle_timeout");
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_fill_valid(output bit seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (n < 1000) begin
      @(negedge clk);
      if (fill_valid) begin
        seen = 1'b1;
        break;
      end
      n++;
    end
    if (!seen) note_fail("fill_valid_timeout");
  endtask

  task automatic flush_model();
    addr_q.delete();
    crit_q.delete();
    faddr_q.delete();
    fdata_q.delete();
    ferr_q.delete();
    for (int i = 0; i < LW; i++) line_m[i] = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    int cnt;
    logic [AW-1:0] a;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    for (int i = 0; i < LW; i++) line_m[i] = '0;
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_read_en", qspi_read_en, 1'b0);
    check("rst_crit_valid", crit_valid, 1'b0);
    check("rst_fill_valid", fill_valid, 1'b0);
    check("rst_fill_err", fill_err, 1'b0);
    check("rst_qspi_addr", qspi_addr, '0);
    check("rst_fill_addr", fill_addr, '0);
    check("rst_crit_data", crit_data, '0);
    check("rst_fill_data", fill_data, '0);
    check("rst_state", dbg_state, IDLE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // aligned fill with known flash words, then critical-word-first
    mem[32'h100] = 32'h0000_00A0;
    mem[32'h104] = 32'h0000_00A1;
    mem[32'h108] = 32'h0000_00A2;
    mem[32'h10C] = 32'h0000_00A3;
    issue(24'h000100);
    wait_idle();
    check("aligned_line", fill_data, 128'h000000A3_000000A2_000000A1_000000A0);
    issue(24'h00010E);
    wait_idle();

    // QSPI backpressure, then cache backpressure with a competing request
    @(negedge clk);
    rr_mode = 2;
    fr_mode = 2;
    issue(24'h000344);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("read_en_held_off", qspi_read_en, 1'b0);
    end
    rr_mode = 0;
    wait_fill_valid(seen);
    req_addr  = 24'h000500;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_fill_valid", fill_valid, 1'b1);
      check("bp_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    fr_mode   = 0;
    wait_idle();

    // watchdog expiry on the third word of an aligned line
    drop_en   = 1'b1;
    drop_addr = 24'h000608;
    issue(24'h000600);
    wait_fill_valid(seen);
    if (seen) check("timeout_latency", 32'(cyc - drop_cyc), 32'(TO + 1));
    wait_idle();
    drop_en = 1'b0;

    // data arriving on the final permitted cycle is not an error
    fixed_lat = 19;
    issue(24'h000704);
    wait_idle();
    fixed_lat = -1;

    // stray data beats outside WAIT
    stray_en = 1'b1;
    issue(24'h000808);
    issue(24'h00090C);
    wait_idle();
    stray_en = 1'b0;

    // reset while waiting for the third word
    fixed_lat = 10;
    issue(24'h000244);
    cnt = 0;
    for (int n = 0; n < 500 && cnt < 3; n++) begin
      @(negedge clk);
      if (qspi_read_en) cnt++;
    end
    if (cnt < 3) note_fail("mid_fill_reach");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_read_en", qspi_read_en, 1'b0);
    check("mrst_fill_valid", fill_valid, 1'b0);
    check("mrst_crit_valid", crit_valid, 1'b0);
    check("mrst_req_ready", req_ready, 1'b1);
    flush_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fixed_lat = -1;
    issue(24'h000200);
    wait_idle();

    // randomized traffic with back-to-back requests
    rr_mode  = 1;
    fr_mode  = 1;
    stray_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        wait_idle();
        drop_en   = 1'b1;
        drop_addr = AW'(((32'(a) / LB) * LB) + 4 * $urandom_range(0, LW - 1));
        issue(a);
        wait_idle();
        drop_en = 1'b0;
      end else begin
        issue(a);
      end
    end
    wait_idle();
    rr_mode  = 0;
    fr_mode  = 0;
    stray_en = 1'b0;
    repeat (10) @(negedge clk);

    check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    check("crit_q_drained", 32'(crit_q.size()), 32'd0);
    check("fill_q_drained", 32'(fdata_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    note_fail("global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
